input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Upstream stage of the LED-sequence top: conditions raw board buttons and switches before they reach the
//  sequence/colour/counter logic. Each input gets a 2-FF synchronizer and a stability-counter debouncer.
//  Buttons also get a one-cycle pulse on each debounced press, so one physical press yields exactly one
//  sequence/colour step.
// PARAMETERS
//  n_SW       4         number of switch inputs
//  n_BTN      4         number of button inputs
//  n_DEB      20        width of per-channel stability counter
//  N_STABLE   1000000   cycles a synchronized level must hold to be accepted (10 ms @ 100 MHz);
//                       legal range 2..2^n_DEB; benches use 4
// PORTS
//  i_clk        in   1       system clock, all logic on rising edge
//  i_reset      in   1       synchronous, active-high reset
//  i_sw         in   n_SW    raw asynchronous switches
//  i_btn        in   n_BTN   raw asynchronous buttons
//  o_sw         out  n_SW    debounced switch levels
//  o_btn        out  n_BTN   debounced button levels
//  o_btn_pulse  out  n_BTN   1-cycle strobe per debounced button rising edge
// BEHAVIOUR
//  - Reset (i_reset=1 at a rising edge):
//    - sync FFs, counters, outputs -> 0; every channel FSM -> S_LOW.
//    - Dominates all other activity, including mid-debounce; no pulse is emitted during or on exit from reset.
//  - Sync: 2-FF chain per bit; FSM sees ff2 ("s").
//  - Per-channel FSM (states in package), counter cnt:
//    - S_LOW : s=1 -> S_RISE, cnt<=0; else stay.
//    - S_RISE: s=0 -> S_LOW (glitch rejected, no output change);
//              s=1 & cnt==N_STABLE-1 -> S_HIGH;
//              else cnt<=cnt+1.
//    - S_HIGH: s=0 -> S_FALL, cnt<=0; else stay.
//    - S_FALL: s=1 -> S_HIGH (no output change);
//              s=0 & cnt==N_STABLE-1 -> S_LOW;
//              else cnt<=cnt+1.
//  - Level output: registered; 1 in S_HIGH/S_FALL, 0 in S_LOW/S_RISE.
//  - Latency: raw edge captured at clock edge E0 -> level changes after edge E0+N_STABLE+2.
//  - Glitches: any excursion held <N_STABLE synchronized cycles is invisible at output.
//  - Pulse:
//    - o_btn_pulse[k]=1 for exactly the cycle after the S_RISE->S_HIGH transition, coincident with o_btn[k] rising.
//    - Never on a fall; never repeated while held.
//    - Switch channels generate no pulse.
//  - Counter: cnt never exceeds N_STABLE-1, no wrap; compare is n_DEB wide.
//  - Channels are fully independent; simultaneous presses give simultaneous pulses.
// STRUCTURE
//  - Package input_conditioner_pkg: 2-bit state encoding (S_LOW=0, S_RISE=1, S_HIGH=2, S_FALL=3).
//  - One sub-module deb_channel:
//    - Contents: synchronizer + FSM + counter + level/pulse, params n_DEB, N_STABLE.
//    - Instantiated by generate loop n_SW+n_BTN times; switch instances leave pulse unconnected.
// TESTING (N_STABLE=4, 10 ns clock)
//  1. Reset held 5 cycles with i_btn=4'b1111 -> all outputs 0 throughout; release with i_btn=0 -> outputs stay 0.
//  2. i_btn[0] 0->1 held 20 cycles -> o_btn[0]=1 after edge E0+6; o_btn_pulse[0]=1 for exactly that one cycle;
//     no second pulse while held.
//  3. i_btn[1] high for 3 cycles then low -> o_btn[1], o_btn_pulse[1] remain 0.
//  4. Chatter: i_btn[2] toggling every 2 cycles for 20 cycles, then stable 1 ->
//     single pulse, 6 edges after last toggle.
//  5. i_sw=4'b0111 stable -> o_sw=4'b0111 after 6 edges; o_btn_pulse unaffected;
//     brief 2-cycle low on i_sw[0] -> o_sw unchanged.
//  6. Reset asserted mid-S_RISE on i_btn[3] -> no pulse; after release with input still high,
//     full N_STABLE debounce restarts and exactly one pulse follows.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: debounce FSM state encoding
// and small helpers used by every channel.
package input_conditioner_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_LOW  = 2'd0;
    localparam logic [STATE_W-1:0] S_RISE = 2'd1;
    localparam logic [STATE_W-1:0] S_HIGH = 2'd2;
    localparam logic [STATE_W-1:0] S_FALL = 2'd3;

    // The accepted level is high while stable-high or while a fall is still unconfirmed.
    function automatic logic state_is_high(input logic [STATE_W-1:0] st);
        return (st == S_HIGH) || (st == S_FALL);
    endfunction

endpackage

// File: rtl/input_conditioner_deb_channel.sv
// One conditioned input: 2-FF synchronizer, stability-counter debounce FSM,
// registered level and a one-cycle strobe on each accepted rising edge.
module deb_channel
    import input_conditioner_pkg::*;
#(
    parameter int n_DEB    = 20,
    parameter int N_STABLE = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    localparam logic [n_DEB-1:0] CNT_MAX = n_DEB'(N_STABLE - 1);

    logic               ff1_q;
    logic               s_q;
    logic [STATE_W-1:0] state_q, state_d;
    logic [n_DEB-1:0]   cnt_q, cnt_d;
    logic               level_q, level_d;
    logic               pulse_q, pulse_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            S_LOW: begin
                if (s_q) begin
                    state_d = S_RISE;
                    cnt_d   = '0;
                end
            end
            S_RISE: begin
                if (!s_q) begin
                    state_d = S_LOW;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_HIGH;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!s_q) begin
                    state_d = S_FALL;
                    cnt_d   = '0;
                end
            end
            S_FALL: begin
                if (s_q) begin
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
        // Level is registered from the next state so it moves on the same edge as the FSM.
        level_d = state_is_high(state_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ff1_q   <= 1'b0;
            s_q     <= 1'b0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            ff1_q   <= i_raw;
            s_q     <= ff1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_level = level_q;
    assign o_pulse = pulse_q;

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: every switch and button gets its own independent
// debounce channel; only button channels expose the press strobe.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int n_SW     = 4,
    parameter int n_BTN    = 4,
    parameter int n_DEB    = 20,
    parameter int N_STABLE = 1000000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [n_SW-1:0]  i_sw,
    input  logic [n_BTN-1:0] i_btn,
    output logic [n_SW-1:0]  o_sw,
    output logic [n_BTN-1:0] o_btn,
    output logic [n_BTN-1:0] o_btn_pulse
);

    localparam int N_CH = n_SW + n_BTN;

    logic [N_CH-1:0] raw_all;
    logic [N_CH-1:0] level_all;

    // Switches occupy the low channel indices, buttons the high ones.
    assign raw_all = {i_btn, i_sw};

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        if (ch < n_SW) begin : g_sw
            deb_channel #(
                .n_DEB    (n_DEB),
                .N_STABLE (N_STABLE)
            ) u_deb (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_raw   (raw_all[ch]),
                .o_level (level_all[ch]),
                .o_pulse ()
            );
        end else begin : g_btn
            deb_channel #(
                .n_DEB    (n_DEB),
                .N_STABLE (N_STABLE)
            ) u_deb (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_raw   (raw_all[ch]),
                .o_level (level_all[ch]),
                .o_pulse (o_btn_pulse[ch-n_SW])
            );
        end
    end

    assign o_sw  = level_all[n_SW-1:0];
    assign o_btn = level_all[N_CH-1:n_SW];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with N_STABLE=4: latency, glitch
// rejection, chatter, switch paths and reset during debounce.
module tb_input_conditioner;

    localparam int n_SW     = 4;
    localparam int n_BTN    = 4;
    localparam int n_DEB    = 20;
    localparam int N_STABLE = 4;
    localparam int LAT      = N_STABLE + 3; // ticks from setting an input to the output edge

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [n_SW-1:0]  i_sw;
    logic [n_BTN-1:0] i_btn;
    logic [n_SW-1:0]  o_sw;
    logic [n_BTN-1:0] o_btn;
    logic [n_BTN-1:0] o_btn_pulse;

    int n_checks = 0;
    int n_errors = 0;

    input_conditioner #(
        .n_SW     (n_SW),
        .n_BTN    (n_BTN),
        .n_DEB    (n_DEB),
        .N_STABLE (N_STABLE)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_sw        (i_sw),
        .i_btn       (i_btn),
        .o_sw        (o_sw),
        .o_btn       (o_btn),
        .o_btn_pulse (o_btn_pulse)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance past one rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle_idle(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    initial begin
        i_reset = 1'b1;
        i_sw    = '0;
        i_btn   = 4'b1111;

        // 1. reset holds everything low even with buttons pressed
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rst_out", {o_sw, o_btn, o_btn_pulse}, 0);
        end
        i_reset = 1'b0;
        i_btn   = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("rst_exit", {o_sw, o_btn, o_btn_pulse}, 0);
        end

        // 2. clean press on btn0: level after LAT ticks, single pulse
        i_btn = 4'b0001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            check("p_btn", o_btn, (c >= LAT) ? 4'b0001 : 4'b0000);
            check("p_pulse", o_btn_pulse, (c == LAT) ? 4'b0001 : 4'b0000);
        end
        i_btn = '0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("rel_btn", o_btn, (c >= LAT) ? 4'b0000 : 4'b0001);
            check("rel_pulse", o_btn_pulse, 0);
        end

        // 3. 3-cycle glitch on btn1 is rejected
        i_btn = 4'b0010;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 3) i_btn = '0;
            check("gl_btn", o_btn, 0);
            check("gl_pulse", o_btn_pulse, 0);
        end

        // 4. chatter on btn2 then stable high
        for (int t = 0; t < 10; t++) begin
            i_btn = (t % 2 == 0) ? 4'b0100 : 4'b0000;
            for (int c = 0; c < 2; c++) begin
                tick();
                check("ch_btn", o_btn, 0);
                check("ch_pulse", o_btn_pulse, 0);
            end
        end
        i_btn = 4'b0100;
        for (int c = 1; c <= 15; c++) begin
            tick();
            check("ch_st_btn", o_btn, (c >= LAT) ? 4'b0100 : 4'b0000);
            check("ch_st_pulse", o_btn_pulse, (c == LAT) ? 4'b0100 : 4'b0000);
        end
        i_btn = '0;
        settle_idle(10);
        check("ch_rel", o_btn, 0);

        // 5. switches: level follows, no pulses, short dip rejected
        i_sw = 4'b0111;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("sw_lvl", o_sw, (c >= LAT) ? 4'b0111 : 4'b0000);
            check("sw_pulse", o_btn_pulse, 0);
        end
        i_sw = 4'b0110;
        tick();
        tick();
        i_sw = 4'b0111;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("sw_dip", o_sw, 4'b0111);
        end

        // 6. reset mid-debounce on btn3, then full restart
        i_btn = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("md_pre", o_btn_pulse, 0);
        end
        i_reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("md_rst", {o_sw, o_btn, o_btn_pulse}, 0);
        end
        i_reset = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            check("md_btn", o_btn, (c >= LAT) ? 4'b1000 : 4'b0000);
            check("md_pulse", o_btn_pulse, (c == LAT) ? 4'b1000 : 4'b0000);
        end
        i_btn = '0;
        settle_idle(10);

        // simultaneous presses give simultaneous pulses
        i_btn = 4'b0101;
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("sim_pulse", o_btn_pulse, (c == LAT) ? 4'b0101 : 4'b0000);
        end
        check("sim_btn", o_btn, 4'b0101);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
